// File: rtl/dense_layer_param_pkg.sv
// Shared types and helpers for the parametrised dense layer.
// State encoding, width helpers and the output saturation rule.
package dense_layer_param_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FRAC_DEF   = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic int acc_w(input int dw, input int in_dim);
    return 2 * dw + $clog2(in_dim);
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Floor-shift by frac, then clamp into a signed dw-bit range.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] v,
    input int                 frac,
    input int                 dw
  );
    logic signed [63:0] s, hi, lo;
    s  = v >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/dense_layer_param_if.sv
// Run/valid control, input tile, weight ROM port and result bus.
// master = the layer, slave = its environment.
interface dense_layer_param_if
  import dense_layer_param_pkg::*;
#(
  parameter int N       = 10,
  parameter int IN_DIM  = 24,
  parameter int OUT_DIM = 200,
  parameter int DATA_W  = 16,
  parameter int BIAS_EN = 1
);
  localparam int AW = addr_w(OUT_DIM);
  localparam int RW = (IN_DIM + BIAS_EN) * DATA_W;

  logic                          run;
  logic                          relu_en;
  logic [N*IN_DIM*DATA_W-1:0]    d;
  logic                          w_ren;
  logic [AW-1:0]                 w_addr;
  logic [RW-1:0]                 w_rdata;
  logic                          valid;
  logic [N*OUT_DIM*DATA_W-1:0]   q;

  modport master (
    input  run, relu_en, d, w_rdata,
    output w_ren, w_addr, valid, q
  );

  modport slave (
    output run, relu_en, d, w_rdata,
    input  w_ren, w_addr, valid, q
  );

endinterface

// File: rtl/dense_layer_param_dot.sv
// One row's dot product against a weight column, DOT_LAT stages deep.
// Bias, shift, saturation and ReLU are applied in the last stage.
module dense_layer_param_dot
  import dense_layer_param_pkg::*;
#(
  parameter int IN_DIM  = 24,
  parameter int DATA_W  = 16,
  parameter int FRAC    = 8,
  parameter int DOT_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     relu_en,
  input  logic [IN_DIM*DATA_W-1:0] a,
  input  logic [IN_DIM*DATA_W-1:0] w,
  input  logic [DATA_W-1:0]        b,
  output logic [DATA_W-1:0]        y
);
  localparam int ACC_W = acc_w(DATA_W, IN_DIM);
  localparam int PW    = 2 * DATA_W;

  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_acc_l;
  logic signed [DATA_W-1:0] w_b_l;
  logic signed [63:0]       w_tot;
  logic signed [63:0]       w_sat;
  logic [DATA_W-1:0]        w_y;

  always_comb begin
    logic signed [DATA_W-1:0] w_ak;
    logic signed [DATA_W-1:0] w_wk;
    w_sum = '0;
    w_ak  = '0;
    w_wk  = '0;
    for (int k = 0; k < IN_DIM; k++) begin
      w_ak  = a[k*DATA_W +: DATA_W];
      w_wk  = w[k*DATA_W +: DATA_W];
      w_sum = w_sum + ACC_W'(PW'(w_ak) * PW'(w_wk));
    end
  end

  if (DOT_LAT == 1) begin : g_lat1
    assign w_acc_l = w_sum;
    assign w_b_l   = b;
  end else begin : g_latn
    logic signed [ACC_W-1:0]  r_acc [DOT_LAT-1];
    logic signed [DATA_W-1:0] r_b   [DOT_LAT-1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DOT_LAT - 1; i++) begin
          r_acc[i] <= '0;
          r_b[i]   <= '0;
        end
      end else begin
        r_acc[0] <= w_sum;
        r_b[0]   <= b;
        for (int i = 1; i < DOT_LAT - 1; i++) begin
          r_acc[i] <= r_acc[i-1];
          r_b[i]   <= r_b[i-1];
        end
      end
    end

    assign w_acc_l = r_acc[DOT_LAT-2];
    assign w_b_l   = r_b[DOT_LAT-2];
  end

  assign w_tot = 64'(w_acc_l) + (64'(w_b_l) <<< FRAC);
  assign w_sat = sat_shift(w_tot, FRAC, DATA_W);
  assign w_y   = (relu_en && w_sat < 64'sd0) ? '0 : w_sat[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) y <= '0;
    else        y <= w_y;
  end

endmodule

// File: rtl/dense_layer_param.sv
// Fully-connected layer: issues one weight column per cycle and
// writes each column of q as its tagged result leaves the dot units.
module dense_layer_param
  import dense_layer_param_pkg::*;
#(
  parameter int N       = 10,
  parameter int IN_DIM  = 24,
  parameter int OUT_DIM = 200,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int FRAC    = FRAC_DEF,
  parameter int DOT_LAT = 2,
  parameter int BIAS_EN = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  dense_layer_param_if.master bus
);
  localparam int AW   = addr_w(OUT_DIM);
  localparam int TAGS = DOT_LAT + 1;
  localparam int RV   = IN_DIM * DATA_W;
  localparam logic [AW-1:0] LAST = AW'(OUT_DIM - 1);

  state_e               r_state;
  logic                 r_wren;
  logic                 r_valid;
  logic                 r_relu;
  logic [AW-1:0]        r_waddr;
  logic [N*RV-1:0]      r_d;
  logic                 r_tag_v [TAGS];
  logic [AW-1:0]        r_tag_c [TAGS];
  logic [DATA_W-1:0]    r_q [N][OUT_DIM];
  logic [DATA_W-1:0]    w_y [N];
  logic [DATA_W-1:0]    w_b;
  logic                 w_wb;
  logic                 w_last_wb;

  if (BIAS_EN != 0) begin : g_bias
    assign w_b = bus.w_rdata[RV +: DATA_W];
  end else begin : g_nobias
    assign w_b = '0;
  end

  for (genvar n = 0; n < N; n++) begin : g_dot
    dense_layer_param_dot #(
      .IN_DIM  (IN_DIM),
      .DATA_W  (DATA_W),
      .FRAC    (FRAC),
      .DOT_LAT (DOT_LAT)
    ) u_dot (
      .clk     (clk),
      .rst_n   (rst_n),
      .relu_en (r_relu),
      .a       (r_d[n*RV +: RV]),
      .w       (bus.w_rdata[RV-1:0]),
      .b       (w_b),
      .y       (w_y[n])
    );
  end

  assign w_wb      = r_tag_v[TAGS-1];
  assign w_last_wb = w_wb && (r_tag_c[TAGS-1] == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wren  <= 1'b0;
      r_valid <= 1'b0;
      r_relu  <= 1'b0;
      r_waddr <= '0;
      r_d     <= '0;
      for (int i = 0; i < TAGS; i++) begin
        r_tag_v[i] <= 1'b0;
        r_tag_c[i] <= '0;
      end
      for (int n = 0; n < N; n++) begin
        for (int c = 0; c < OUT_DIM; c++) begin
          r_q[n][c] <= '0;
        end
      end
    end else if (!bus.run) begin
      // Abort: flushing the tags blocks every pending q write.
      r_state <= S_IDLE;
      r_wren  <= 1'b0;
      r_valid <= 1'b0;
      for (int i = 0; i < TAGS; i++) begin
        r_tag_v[i] <= 1'b0;
      end
    end else begin
      r_tag_v[0] <= r_wren;
      r_tag_c[0] <= r_waddr;
      for (int i = 1; i < TAGS; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_c[i] <= r_tag_c[i-1];
      end
      if (w_wb) begin
        for (int n = 0; n < N; n++) begin
          r_q[n][r_tag_c[TAGS-1]] <= w_y[n];
        end
      end
      unique case (r_state)
        S_IDLE: begin
          r_d     <= bus.d;
          r_relu  <= bus.relu_en;
          r_wren  <= 1'b1;
          r_waddr <= '0;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (r_waddr == LAST) begin
            r_wren  <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_waddr <= r_waddr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_last_wb) begin
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_valid <= 1'b1;
        end
      endcase
    end
  end

  assign bus.w_ren  = r_wren;
  assign bus.w_addr = r_waddr;
  assign bus.valid  = r_valid;

  for (genvar n = 0; n < N; n++) begin : g_qn
    for (genvar c = 0; c < OUT_DIM; c++) begin : g_qc
      assign bus.q[(n*OUT_DIM+c)*DATA_W +: DATA_W] = r_q[n][c];
    end
  end

endmodule

// File: tb/tb_dense_layer_param.sv
// Bench for dense_layer_param: 2 rows, 4 inputs, 3 columns,
// 1-cycle weight ROM model and an integer reference model.
module tb_dense_layer_param;
  localparam int N       = 2;
  localparam int IN_DIM  = 4;
  localparam int OUT_DIM = 3;
  localparam int DATA_W  = 16;
  localparam int FRAC    = 8;
  localparam int DOT_LAT = 1;
  localparam int BIAS_EN = 1;
  localparam int LAT     = OUT_DIM + DOT_LAT + 2;
  localparam int TMO     = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dense_layer_param_if #(
    .N(N), .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM),
    .DATA_W(DATA_W), .BIAS_EN(BIAS_EN)
  ) bus ();

  dense_layer_param #(
    .N(N), .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .DATA_W(DATA_W),
    .FRAC(FRAC), .DOT_LAT(DOT_LAT), .BIAS_EN(BIAS_EN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] tb_d  [N][IN_DIM];
  logic [15:0] rom_w [OUT_DIM][IN_DIM];
  logic [15:0] rom_b [OUT_DIM];
  logic [15:0] exp_q [N][OUT_DIM];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always_comb begin
    bus.d = '0;
    for (int n = 0; n < N; n++)
      for (int k = 0; k < IN_DIM; k++)
        bus.d[(n*IN_DIM+k)*DATA_W +: DATA_W] = tb_d[n][k];
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      bus.w_rdata <= '0;
    end else if (bus.w_ren) begin
      for (int k = 0; k < IN_DIM; k++)
        bus.w_rdata[k*DATA_W +: DATA_W] <= rom_w[int'(bus.w_addr)][k];
      bus.w_rdata[IN_DIM*DATA_W +: DATA_W] <= rom_b[int'(bus.w_addr)];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] get_q(int n, int c);
    return bus.q[(n*OUT_DIM+c)*DATA_W +: DATA_W];
  endfunction

  // Real-valued layer in Q8: exact sum, add bias, floor, clamp, ReLU.
  function automatic logic [15:0] ref_q(int n, int c, logic relu);
    longint acc;
    acc = longint'($signed(rom_b[c])) * 256;
    for (int k = 0; k < IN_DIM; k++)
      acc += longint'($signed(tb_d[n][k])) * longint'($signed(rom_w[c][k]));
    if (acc < 0) acc = -((-acc + 255) / 256);
    else         acc = acc / 256;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return 16'(acc);
  endfunction

  task automatic predict(input logic relu);
    for (int n = 0; n < N; n++)
      for (int c = 0; c < OUT_DIM; c++)
        exp_q[n][c] = ref_q(n, c, relu);
  endtask

  function automatic logic [15:0] rnd(input bit big);
    if (big) return 16'($urandom);
    return 16'(int'($urandom_range(0, 1023)) - 512);
  endfunction

  task automatic fill_const(input logic [15:0] dv, input logic [15:0] wv,
                            input logic [15:0] bv);
    for (int n = 0; n < N; n++)
      for (int k = 0; k < IN_DIM; k++) tb_d[n][k] = dv;
    for (int c = 0; c < OUT_DIM; c++) begin
      rom_b[c] = bv;
      for (int k = 0; k < IN_DIM; k++) rom_w[c][k] = wv;
    end
  endtask

  task automatic fill_rand(input bit big);
    for (int n = 0; n < N; n++)
      for (int k = 0; k < IN_DIM; k++) tb_d[n][k] = rnd(big);
    for (int c = 0; c < OUT_DIM; c++) begin
      rom_b[c] = rnd(big);
      for (int k = 0; k < IN_DIM; k++) rom_w[c][k] = rnd(big);
    end
  endtask

  task automatic start_wait(output int lat);
    bus.run = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.valid && lat < TMO);
  endtask

  task automatic stop_run();
    bus.run = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (bus.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.valid);
    else n_pass++;
    n_chk++;
    if (bus.w_ren !== 1'b0) $display("FAIL reset_wren got %b want 0", bus.w_ren);
    else n_pass++;
    n_chk++;
    if (bus.w_addr !== '0) $display("FAIL reset_waddr got %0d want 0", bus.w_addr);
    else n_pass++;
    n_chk++;
    if (bus.q !== '0) $display("FAIL reset_q got %h want 0", bus.q);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_const();
    int lat;
    fill_const(16'h0100, 16'h0080, 16'h0040);
    bus.relu_en = 1'b0;
    predict(1'b0);
    start_wait(lat);
    n_chk++;
    if (lat !== LAT) $display("FAIL const_latency got %0d want %0d", lat, LAT);
    else n_pass++;
    for (int n = 0; n < N; n++)
      for (int c = 0; c < OUT_DIM; c++) begin
        n_chk++;
        if (get_q(n, c) !== 16'h0240 || exp_q[n][c] !== 16'h0240)
          $display("FAIL const_q[%0d][%0d] got %h want 0240", n, c, get_q(n, c));
        else n_pass++;
      end
    stop_run();
    n_chk++;
    if (bus.valid !== 1'b0) $display("FAIL const_valid_drop got %b want 0", bus.valid);
    else n_pass++;
  endtask

  task automatic test_relu();
    int lat;
    fill_const(16'h0100, 16'h0100, 16'h0000);
    for (int k = 0; k < IN_DIM; k++) tb_d[0][k] = 16'hFF00;
    for (int r = 0; r < 2; r++) begin
      bus.relu_en = 1'(r);
      predict(1'(r));
      start_wait(lat);
      n_chk++;
      if (lat !== LAT) $display("FAIL relu%0d_latency got %0d want %0d", r, lat, LAT);
      else n_pass++;
      for (int c = 0; c < OUT_DIM; c++) begin
        n_chk++;
        if (get_q(0, c) !== (r == 0 ? 16'hFC00 : 16'h0000))
          $display("FAIL relu%0d_row0[%0d] got %h want %h", r, c, get_q(0, c),
                   (r == 0 ? 16'hFC00 : 16'h0000));
        else n_pass++;
        n_chk++;
        if (get_q(1, c) !== exp_q[1][c])
          $display("FAIL relu%0d_row1[%0d] got %h want %h", r, c, get_q(1, c), exp_q[1][c]);
        else n_pass++;
      end
      stop_run();
    end
  endtask

  task automatic test_saturate();
    int lat;
    logic [15:0] want;
    bus.relu_en = 1'b0;
    for (int s = 0; s < 2; s++) begin
      fill_const(16'h7F00, (s == 0) ? 16'h7F00 : 16'h8100, 16'h0000);
      want = (s == 0) ? 16'h7FFF : 16'h8000;
      start_wait(lat);
      n_chk++;
      if (lat !== LAT) $display("FAIL sat%0d_latency got %0d want %0d", s, lat, LAT);
      else n_pass++;
      for (int n = 0; n < N; n++)
        for (int c = 0; c < OUT_DIM; c++) begin
          n_chk++;
          if (get_q(n, c) !== want)
            $display("FAIL sat%0d_q[%0d][%0d] got %h want %h", s, n, c, get_q(n, c), want);
          else n_pass++;
        end
      stop_run();
    end
  endtask

  task automatic test_abort();
    int lat;
    logic [N*OUT_DIM*DATA_W-1:0] snap;
    fill_rand(1'b0);
    bus.relu_en = 1'b0;
    predict(1'b0);
    snap = bus.q;
    bus.run = 1'b1;
    tick();
    tick();
    n_chk++;
    if (bus.w_addr !== 2'd1) $display("FAIL abort_col got %0d want 1", bus.w_addr);
    else n_pass++;
    bus.run = 1'b0;
    tick();
    n_chk++;
    if (bus.w_ren !== 1'b0) $display("FAIL abort_wren got %b want 0", bus.w_ren);
    else n_pass++;
    repeat (5) tick();
    n_chk++;
    if (bus.q !== snap || bus.valid !== 1'b0)
      $display("FAIL abort_hold got q=%h v=%b want q=%h v=0", bus.q, bus.valid, snap);
    else n_pass++;
    start_wait(lat);
    n_chk++;
    if (lat !== LAT) $display("FAIL rerun_latency got %0d want %0d", lat, LAT);
    else n_pass++;
    for (int n = 0; n < N; n++)
      for (int c = 0; c < OUT_DIM; c++) begin
        n_chk++;
        if (get_q(n, c) !== exp_q[n][c])
          $display("FAIL rerun_q[%0d][%0d] got %h want %h", n, c, get_q(n, c), exp_q[n][c]);
        else n_pass++;
      end
    stop_run();
  endtask

  task automatic test_capture_hold();
    int lat;
    fill_rand(1'b0);
    bus.relu_en = 1'b1;
    predict(1'b1);
    bus.run = 1'b1;
    tick();
    lat = 1;
    for (int n = 0; n < N; n++)
      for (int k = 0; k < IN_DIM; k++) tb_d[n][k] = rnd(1'b0);
    bus.relu_en = 1'b0;
    while (!bus.valid && lat < TMO) begin
      tick();
      lat++;
    end
    n_chk++;
    if (lat !== LAT) $display("FAIL capture_latency got %0d want %0d", lat, LAT);
    else n_pass++;
    for (int n = 0; n < N; n++)
      for (int c = 0; c < OUT_DIM; c++) begin
        n_chk++;
        if (get_q(n, c) !== exp_q[n][c])
          $display("FAIL capture_q[%0d][%0d] got %h want %h", n, c, get_q(n, c), exp_q[n][c]);
        else n_pass++;
      end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++;
      if (bus.valid !== 1'b1 || bus.w_ren !== 1'b0)
        $display("FAIL hold%0d got v=%b ren=%b want v=1 ren=0", i, bus.valid, bus.w_ren);
      else n_pass++;
    end
    stop_run();
  endtask

  task automatic test_random();
    int lat;
    logic relu;
    for (int it = 0; it < 6; it++) begin
      fill_rand(it[0]);
      relu = 1'($urandom_range(0, 1));
      bus.relu_en = relu;
      predict(relu);
      start_wait(lat);
      n_chk++;
      if (lat !== LAT) $display("FAIL rand%0d_latency got %0d want %0d", it, lat, LAT);
      else n_pass++;
      for (int n = 0; n < N; n++)
        for (int c = 0; c < OUT_DIM; c++) begin
          n_chk++;
          if (get_q(n, c) !== exp_q[n][c])
            $display("FAIL rand%0d_q[%0d][%0d] got %h want %h", it, n, c,
                     get_q(n, c), exp_q[n][c]);
          else n_pass++;
        end
      stop_run();
    end
  endtask

  task automatic test_reset_mid_done();
    int lat;
    fill_rand(1'b0);
    bus.relu_en = 1'b0;
    start_wait(lat);
    n_chk++;
    if (bus.valid !== 1'b1) $display("FAIL mid_done_reach got %b want 1", bus.valid);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    n_chk++;
    if (bus.valid !== 1'b0 || bus.w_ren !== 1'b0)
      $display("FAIL mid_reset_ctl got v=%b ren=%b want 0 0", bus.valid, bus.w_ren);
    else n_pass++;
    n_chk++;
    if (bus.q !== '0) $display("FAIL mid_reset_q got %h want 0", bus.q);
    else n_pass++;
    rst_n = 1'b1;
    bus.run = 1'b0;
    tick();
  endtask

  initial begin
    bus.run = 1'b0;
    bus.relu_en = 1'b0;
    fill_const(16'h0000, 16'h0000, 16'h0000);
    test_reset();
    test_const();
    test_relu();
    test_saturate();
    test_abort();
    test_capture_hold();
    test_random();
    test_reset_mid_done();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
